// File: rtl/riscv_pkg.sv
// Shared types and constants for the single-cycle RISC-V core and its boot sequencer.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } boot_state_e;

endpackage

// File: rtl/boot_halt_detector.sv
// Run-termination conditions: PC self-loop and cycle-budget exhaustion.
module boot_halt_detector #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CYC_W = 16
) (
    input  logic [CYC_W-1:0] cycles_run,
    input  logic [CYC_W-1:0] run_budget,
    input  logic [PC_W-1:0]  core_pc,
    input  logic [PC_W-1:0]  prev_pc,
    output logic             loop_hit,
    output logic             budget_hit
);

    // One extra bit so the +1 cannot wrap when cycles_run is saturated.
    logic [CYC_W:0] cnt_next;

    always_comb begin
        cnt_next   = {1'b0, cycles_run} + (CYC_W+1)'(1);
        loop_hit   = (cycles_run != '0) && (core_pc == prev_pc);
        budget_hit = (run_budget != '0) && (cnt_next == {1'b0, run_budget});
    end

endmodule

// File: rtl/imem_boot_sequencer.sv
// Streams a program into IMEM with the core held in reset, then runs the core until
// it self-loops or its cycle budget runs out.
module imem_boot_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter int unsigned CYC_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic             load_valid,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    input  logic [31:0]      core_pc,
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             halt_loop,
    output logic [31:0]      words_loaded,
    output logic [CYC_W-1:0] cycles_run
);

    localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(IMEM_BYTES - WORD_BYTES);

    boot_state_e      state, state_n;
    logic [XLEN-1:0]  wr_ptr;
    logic [XLEN-1:0]  prev_pc;
    logic [CYC_W-1:0] run_budget;
    logic             accept_start;
    logic             handshake;
    logic             loop_hit;
    logic             budget_hit;

    boot_halt_detector #(
        .PC_W  (XLEN),
        .CYC_W (CYC_W)
    ) u_halt (
        .cycles_run (cycles_run),
        .run_budget (run_budget),
        .core_pc    (core_pc),
        .prev_pc    (prev_pc),
        .loop_hit   (loop_hit),
        .budget_hit (budget_hit)
    );

    always_comb begin
        state_n      = state;
        accept_start = 1'b0;
        handshake    = 1'b0;
        load_ready   = 1'b0;
        core_reset   = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_n      = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                handshake  = load_valid;
                if (load_valid && (load_last || wr_ptr == LAST_ADDR))
                    state_n = RELEASE;
            end
            RELEASE: begin
                busy    = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                busy       = 1'b1;
                if (loop_hit || budget_hit)
                    state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept_start = 1'b1;
                    state_n      = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign imem_we    = load_valid & load_ready;
    assign imem_addr  = wr_ptr;
    assign imem_wdata = load_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            words_loaded <= '0;
            cycles_run   <= '0;
            prev_pc      <= '0;
            halt_loop    <= 1'b0;
            run_budget   <= '0;
        end else begin
            state <= state_n;
            if (accept_start) begin
                wr_ptr       <= '0;
                words_loaded <= '0;
                cycles_run   <= '0;
                halt_loop    <= 1'b0;
                run_budget   <= run_cycles;
            end
            if (handshake) begin
                wr_ptr       <= wr_ptr + XLEN'(WORD_BYTES);
                words_loaded <= words_loaded + 32'd1;
            end
            if (state == RUN) begin
                prev_pc <= core_pc;
                if (cycles_run != '1)
                    cycles_run <= cycles_run + CYC_W'(1);
                // A simultaneous loop and budget hit reports as a self-loop halt.
                if (state_n == DONE)
                    halt_loop <= loop_hit;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench: a default-size sequencer driving a tiny core model, plus a
// 16-byte instance for the capacity limit.
module tb_imem_boot_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [15:0] run_cycles;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;

    logic        m_ready, m_we, m_core_reset, m_busy, m_done, m_halt;
    logic [31:0] m_addr, m_wdata, m_words;
    logic [15:0] m_cycles;
    logic        s_ready, s_we, s_core_reset, s_busy, s_done, s_halt;
    logic [31:0] s_addr, s_wdata, s_words;
    logic [15:0] s_cycles;
    logic [31:0] core_pc;
    logic [31:0] small_pc;

    logic        m_start, s_start;
    logic        e_ready, e_we, e_core_reset, e_busy, e_done, e_halt;
    logic [31:0] e_addr, e_wdata, e_words;
    logic [15:0] e_cycles;

    always #5 clk = ~clk;

    assign m_start      = start & ~sel;
    assign s_start      = start & sel;
    assign small_pc     = 32'h0;
    assign e_ready      = sel ? s_ready      : m_ready;
    assign e_we         = sel ? s_we         : m_we;
    assign e_core_reset = sel ? s_core_reset : m_core_reset;
    assign e_busy       = sel ? s_busy       : m_busy;
    assign e_done       = sel ? s_done       : m_done;
    assign e_halt       = sel ? s_halt       : m_halt;
    assign e_addr       = sel ? s_addr       : m_addr;
    assign e_wdata      = sel ? s_wdata      : m_wdata;
    assign e_words      = sel ? s_words      : m_words;
    assign e_cycles     = sel ? s_cycles     : m_cycles;

    imem_boot_sequencer #(.IMEM_BYTES(1024), .CYC_W(16)) dut (
        .clk(clk), .reset(reset), .start(m_start), .run_cycles(run_cycles),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(m_ready), .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
        .core_pc(core_pc), .core_reset(m_core_reset), .busy(m_busy), .done(m_done),
        .halt_loop(m_halt), .words_loaded(m_words), .cycles_run(m_cycles)
    );

    imem_boot_sequencer #(.IMEM_BYTES(16), .CYC_W(16)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .run_cycles(run_cycles),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .core_pc(small_pc), .core_reset(s_core_reset), .busy(s_busy), .done(s_done),
        .halt_loop(s_halt), .words_loaded(s_words), .cycles_run(s_cycles)
    );

    // Core stand-in: PC advances by 4 unless the fetched word is jal x0,0.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (m_core_reset)
            core_pc <= 32'h0;
        else if (mem[core_pc[9:2]] != 32'h0000006f)
            core_pc <= core_pc + 32'd4;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t sbq[$];

    always @(negedge clk) begin
        if (e_we === 1'b1) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                         e_addr, e_wdata);
            end else begin
                wr_t w;
                w = sbq.pop_front();
                check("write_addr", e_addr, w.addr);
                check("write_data", e_wdata, w.data);
            end
            if (!sel) mem[e_addr[9:2]] = e_wdata;
        end
    end

    int unsigned exp_addr;
    int unsigned exp_cnt;
    int unsigned cap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] rc, input logic s);
        sel        = s;
        run_cycles = rc;
        start      = 1'b1;
        exp_addr   = 0;
        exp_cnt    = 0;
        cap        = s ? 4 : 256;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last,
                             input int unsigned gap, input logic pulse);
        for (int unsigned g = 0; g < gap; g++) begin
            load_valid = 1'b0;
            start      = pulse;
            tick();
        end
        start      = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        if (exp_cnt < cap) begin
            sbq.push_back('{addr: exp_addr, data: d});
            exp_addr += 4;
            exp_cnt++;
        end
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done(output int unsigned run_cnt);
        bit hit;
        hit     = 1'b0;
        run_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (e_done) begin
                hit = 1'b1;
                break;
            end
            if (!e_core_reset) run_cnt++;
            tick();
        end
        if (!hit) check("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        bit          jal_prog;
        int unsigned n_words;
        logic [15:0] rc;
        int unsigned gap;
        bit          pulse;
        int unsigned exp_cyc;
        bit          exp_loop;
    } row_t;
    row_t rows[5];

    initial begin
        int unsigned  cnt;
        logic [31:0]  prog3 [3];
        logic [31:0]  w;

        rows[0] = '{1'b1, 1, 16'd0, 0, 1'b0, 2, 1'b1};
        rows[1] = '{1'b0, 6, 16'd5, 0, 1'b0, 5, 1'b0};
        rows[2] = '{1'b1, 1, 16'd1, 0, 1'b0, 1, 1'b0};
        rows[3] = '{1'b1, 1, 16'd2, 0, 1'b0, 2, 1'b1};
        rows[4] = '{1'b0, 3, 16'd3, 2, 1'b1, 3, 1'b0};
        prog3[0] = 32'h123450b7;
        prog3[1] = 32'h00001117;
        prog3[2] = 32'h00a08193;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1; start = 1'b0; sel = 1'b0; run_cycles = '0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_core_reset", {31'b0, m_core_reset}, 32'd1);
        check("rst_ready", {31'b0, m_ready}, 32'd0);
        check("rst_busy", {31'b0, m_busy}, 32'd0);
        check("rst_done", {31'b0, m_done}, 32'd0);
        check("rst_halt", {31'b0, m_halt}, 32'd0);
        check("rst_words", m_words, 32'd0);
        check("rst_cycles", {16'b0, m_cycles}, 32'd0);
        check("rst_small_core_reset", {31'b0, s_core_reset}, 32'd1);

        // Three-word load, then reset in the third RUN cycle.
        do_start(16'd0, 1'b0);
        check("t1_ready", {31'b0, e_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send_word(prog3[i], (i == 2), 0, 1'b0);
            check("t1_words", e_words, 32'(i + 1));
        end
        check("t1_release_core_reset", {31'b0, e_core_reset}, 32'd1);
        check("t1_release_ready", {31'b0, e_ready}, 32'd0);
        check("t1_release_busy", {31'b0, e_busy}, 32'd1);
        tick();
        check("t1_run_core_reset", {31'b0, e_core_reset}, 32'd0);
        tick(); tick();
        check("t1_run_cycles", {16'b0, e_cycles}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t1_abort_core_reset", {31'b0, e_core_reset}, 32'd1);
        check("t1_abort_done", {31'b0, e_done}, 32'd0);
        check("t1_abort_busy", {31'b0, e_busy}, 32'd0);
        check("t1_abort_words", e_words, 32'd0);
        check("t1_abort_cycles", {16'b0, e_cycles}, 32'd0);
        check("t1_sb_drain", sbq.size(), 32'd0);

        for (int r = 0; r < 5; r++) begin
            do_start(rows[r].rc, 1'b0);
            check("row_start_done", {31'b0, e_done}, 32'd0);
            check("row_start_cycles", {16'b0, e_cycles}, 32'd0);
            check("row_start_halt", {31'b0, e_halt}, 32'd0);
            for (int unsigned i = 0; i < rows[r].n_words; i++) begin
                w = rows[r].jal_prog ? 32'h0000006f : (32'h00000093 | (32'(i + 1) << 20));
                send_word(w, (i == rows[r].n_words - 1), rows[r].gap, rows[r].pulse);
            end
            check("row_words", e_words, rows[r].n_words);
            check("row_release_core_reset", {31'b0, e_core_reset}, 32'd1);
            wait_done(cnt);
            check("row_run_len", cnt, rows[r].exp_cyc);
            check("row_cycles_run", {16'b0, e_cycles}, rows[r].exp_cyc);
            check("row_halt_loop", {31'b0, e_halt}, {31'b0, rows[r].exp_loop});
            check("row_done_core_reset", {31'b0, e_core_reset}, 32'd1);
            check("row_done_busy", {31'b0, e_busy}, 32'd0);
            check("row_sb_drain", sbq.size(), 32'd0);
        end

        // 16-byte instance: six words offered, only four fit.
        do_start(16'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_word(32'hA0000000 | 32'(i), 1'b0, 0, 1'b0);
            if (i == 3) check("cap_ready_after_full", {31'b0, e_ready}, 32'd0);
            if (i == 4) check("cap_enters_run", {31'b0, e_core_reset}, 32'd0);
        end
        check("cap_words", e_words, 32'd4);
        wait_done(cnt);
        check("cap_done", {31'b0, e_done}, 32'd1);
        check("cap_halt_loop", {31'b0, e_halt}, 32'd1);
        check("cap_sb_drain", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
